// File: rtl/am_audio_agc.sv
// AM audio back end: leaky-integrator DC blocker, Q4.4 serial-multiply AGC.
// Optional manual gain override enabled by defining AM_AGC_MANUAL_GAIN_EN.
module am_audio_agc #(
    parameter int unsigned DC_SHIFT        = 10,
    parameter logic [15:0] TARGET          = 16'd8192,
    parameter int unsigned RELEASE_SAMPLES = 256,
    parameter logic [7:0]  GAIN_INIT       = 8'd16
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic [15:0] mag_in,
    input  logic        in_tick,
`ifdef AM_AGC_MANUAL_GAIN_EN
    input  logic        agc_enable,
    input  logic [7:0]  manual_gain,
`endif
    output logic [15:0] audio_out,
    output logic        out_tick,
    output logic [7:0]  gain_out,
    output logic        overrun
);

    localparam int AW = 16 + DC_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DC,
        S_MUL,
        S_SAT,
        S_AGC
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        mag_q, mag_d;
    logic [AW-1:0]      dc_acc_q, dc_acc_d;
    logic signed [24:0] mcand_q, mcand_d;
    logic [7:0]         mplier_q, mplier_d;
    logic signed [24:0] prod_q, prod_d;
    logic [2:0]         bit_q, bit_d;
    logic [15:0]        audio_q, audio_d;
    logic               tick_q, tick_d;
    logic               sat_q, sat_d;
    logic [7:0]         gain_q, gain_d;
    logic [9:0]         rel_q, rel_d;
    logic               ovr_q, ovr_d;

    logic [15:0]        dc_est;
    logic signed [16:0] ac;
    logic signed [24:0] y;
    logic [16:0]        aud_ext;
    logic [16:0]        mabs;
    logic               agc_on;

    assign dc_est  = dc_acc_q[AW-1:DC_SHIFT];
    assign ac      = $signed({1'b0, mag_q}) - $signed({1'b0, dc_est});
    assign y       = prod_q >>> 4;
    assign aud_ext = {audio_q[15], audio_q};
    assign mabs    = aud_ext[16] ? (17'd0 - aud_ext) : aud_ext;

`ifdef AM_AGC_MANUAL_GAIN_EN
    assign agc_on = agc_enable;
`else
    assign agc_on = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        dc_acc_d = dc_acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        bit_d    = bit_q;
        audio_d  = audio_q;
        tick_d   = 1'b0;
        sat_d    = sat_q;
        gain_d   = gain_q;
        rel_d    = rel_q;
        ovr_d    = ovr_q | (in_tick && (state_q != S_IDLE));

        unique case (state_q)
            S_IDLE: begin
                if (in_tick) begin
                    mag_d   = mag_in;
                    state_d = S_DC;
                end
            end
            S_DC: begin
                dc_acc_d = dc_acc_q + AW'(mag_q) - AW'(dc_est);
                mcand_d  = {{8{ac[16]}}, ac};
                mplier_d = gain_q;
                prod_d   = '0;
                bit_d    = '0;
                state_d  = S_MUL;
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q <<< 1;
                mplier_d = mplier_q >> 1;
                bit_d    = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = S_SAT;
                end
            end
            S_SAT: begin
                if (y > 25'sd32767) begin
                    audio_d = 16'h7FFF;
                    sat_d   = 1'b1;
                end else if (y < -25'sd32768) begin
                    audio_d = 16'h8000;
                    sat_d   = 1'b1;
                end else begin
                    audio_d = y[15:0];
                    sat_d   = 1'b0;
                end
                tick_d  = 1'b1;
                state_d = S_AGC;
            end
            S_AGC: begin
                if (!agc_on) begin
`ifdef AM_AGC_MANUAL_GAIN_EN
                    gain_d = (manual_gain == 8'd0) ? 8'd1 : manual_gain;
`endif
                    rel_d  = '0;
                end else if (sat_q || (mabs > {1'b0, TARGET})) begin
                    gain_d = (gain_q > 8'd1) ? gain_q - 8'd1 : 8'd1;
                    rel_d  = '0;
                end else if (mabs < {2'b0, TARGET[15:1]}) begin
                    if (rel_q == 10'(RELEASE_SAMPLES - 1)) begin
                        gain_d = (gain_q == 8'hFF) ? 8'hFF : gain_q + 8'd1;
                        rel_d  = '0;
                    end else begin
                        rel_d = rel_q + 10'd1;
                    end
                end else begin
                    rel_d = '0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q  <= S_IDLE;
            mag_q    <= '0;
            dc_acc_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            bit_q    <= '0;
            audio_q  <= '0;
            tick_q   <= 1'b0;
            sat_q    <= 1'b0;
            gain_q   <= GAIN_INIT;
            rel_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            dc_acc_q <= dc_acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            bit_q    <= bit_d;
            audio_q  <= audio_d;
            tick_q   <= tick_d;
            sat_q    <= sat_d;
            gain_q   <= gain_d;
            rel_q    <= rel_d;
            ovr_q    <= ovr_d;
        end
    end

    assign audio_out = audio_q;
    assign out_tick  = tick_q;
    assign gain_out  = gain_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_am_audio_agc.sv
// Bench for am_audio_agc: vector table, corner sequences, random vs model.
// Four instances cover default, saturating, fast-DC and fast-release setups.
module tb_am_audio_agc;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic [15:0] mag  [4];
    logic        tick [4];
    logic [15:0] aout [4];
    logic        otick[4];
    logic [7:0]  gout [4];
    logic        ovr  [4];

    int errs = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    am_audio_agc u0 (
        .CLK(CLK), .RSTb(RSTb), .mag_in(mag[0]), .in_tick(tick[0]),
`ifdef AM_AGC_MANUAL_GAIN_EN
        .agc_enable(1'b1), .manual_gain(8'd0),
`endif
        .audio_out(aout[0]), .out_tick(otick[0]),
        .gain_out(gout[0]), .overrun(ovr[0]));

    am_audio_agc #(.GAIN_INIT(8'd255)) u1 (
        .CLK(CLK), .RSTb(RSTb), .mag_in(mag[1]), .in_tick(tick[1]),
`ifdef AM_AGC_MANUAL_GAIN_EN
        .agc_enable(1'b1), .manual_gain(8'd0),
`endif
        .audio_out(aout[1]), .out_tick(otick[1]),
        .gain_out(gout[1]), .overrun(ovr[1]));

    am_audio_agc #(.DC_SHIFT(4)) u2 (
        .CLK(CLK), .RSTb(RSTb), .mag_in(mag[2]), .in_tick(tick[2]),
`ifdef AM_AGC_MANUAL_GAIN_EN
        .agc_enable(1'b1), .manual_gain(8'd0),
`endif
        .audio_out(aout[2]), .out_tick(otick[2]),
        .gain_out(gout[2]), .overrun(ovr[2]));

    am_audio_agc #(.RELEASE_SAMPLES(4)) u3 (
        .CLK(CLK), .RSTb(RSTb), .mag_in(mag[3]), .in_tick(tick[3]),
`ifdef AM_AGC_MANUAL_GAIN_EN
        .agc_enable(1'b1), .manual_gain(8'd0),
`endif
        .audio_out(aout[3]), .out_tick(otick[3]),
        .gain_out(gout[3]), .overrun(ovr[3]));

    // Reference model: per-instance DC accumulator, gain and quiet run length.
    int     P_DCS [4] = '{10, 10, 4, 10};
    int     P_REL [4] = '{256, 256, 256, 4};
    int     P_GI  [4] = '{16, 255, 16, 16};
    longint m_acc [4];
    int     m_gain[4];
    int     m_quiet[4];

    function automatic void mdl_reset();
        for (int i = 0; i < 4; i++) begin
            m_acc[i]   = 0;
            m_gain[i]  = P_GI[i];
            m_quiet[i] = 0;
        end
    endfunction

    function automatic int mdl_step(input int i, input int m);
        longint est, ac, p, y, mg;
        int aud;
        bit sat;
        est = (m_acc[i] >> P_DCS[i]) & 64'hFFFF;
        ac = m - est;
        m_acc[i] = m_acc[i] + ac;
        p = ac * m_gain[i];
        y = (p - (((p % 16) + 16) % 16)) / 16;
        sat = (y > 32767) || (y < -32768);
        aud = (y > 32767) ? 32767 : (y < -32768) ? -32768 : int'(y);
        mg = (aud < 0) ? -aud : aud;
        if (sat || mg > 8192) begin
            m_gain[i]  = (m_gain[i] - 1 < 1) ? 1 : m_gain[i] - 1;
            m_quiet[i] = 0;
        end else if (mg < 4096) begin
            m_quiet[i]++;
            if (m_quiet[i] == P_REL[i]) begin
                m_gain[i]  = (m_gain[i] + 1 > 255) ? 255 : m_gain[i] + 1;
                m_quiet[i] = 0;
            end
        end else begin
            m_quiet[i] = 0;
        end
        return aud;
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RSTb = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTb = 1'b1;
    endtask

    // One tick, then gap-1 further edges observed; edges counted from k.
    task automatic pulse(input int i, input logic [15:0] m, input int gap,
                         output int at, output int n,
                         output int aud, output int g);
        mag[i]  = m;
        tick[i] = 1'b1;
        @(posedge CLK);
        #1 tick[i] = 1'b0;
        at = -1; n = 0; aud = 0; g = -1;
        for (int e = 1; e < gap; e++) begin
            @(posedge CLK);
            #1;
            if (otick[i]) begin
                n++;
                if (at < 0) at = e;
                aud = int'($signed(aout[i]));
            end
            if (e == 11) g = int'(gout[i]);
        end
    endtask

    task automatic sample(input int i, input logic [15:0] m, input int gap,
                          input int exp_aud, input int exp_g,
                          input string name);
        int at, n, aud, g;
        pulse(i, m, gap, at, n, aud, g);
        chk({name, " tick_edge"}, at, 10);
        chk({name, " tick_count"}, n, 1);
        chk({name, " audio"}, aud, exp_aud);
        chk({name, " gain"}, g, exp_g);
    endtask

    typedef struct {
        logic [15:0] mag;
        int          aud;
        int          gain;
    } vec_t;

    vec_t vt[5];

    initial begin
        int at, n, aud, g, ea;
        vt[0] = '{16'h4000, 16384, 15};
        vt[1] = '{16'h4000, 15345, 14};
        vt[2] = '{16'h0000, -28, 14};
        vt[3] = '{16'h1000, 3556, 14};
        vt[4] = '{16'h3000, 10721, 13};

        for (int i = 0; i < 4; i++) begin
            mag[i]  = '0;
            tick[i] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1 RSTb = 1'b1;

        chk("reset audio", aout[0], 0);
        chk("reset tick", otick[0], 0);
        chk("reset gain", gout[0], 16);
        chk("reset overrun", ovr[0], 0);
        chk("reset gain u1", gout[1], 255);

        for (int v = 0; v < 5; v++)
            sample(0, vt[v].mag, 14, vt[v].aud, vt[v].gain,
                   $sformatf("vec%0d", v));
        chk("vec overrun", ovr[0], 0);

        // Second tick five cycles into a sample is dropped.
        do_reset();
        mag[0] = 16'h4000; tick[0] = 1'b1;
        @(posedge CLK);
        #1 tick[0] = 1'b0;
        n = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge CLK);
            #1;
            if (otick[0]) n++;
            if (e == 4) tick[0] = 1'b1;
            if (e == 5) tick[0] = 1'b0;
        end
        chk("overrun ticks", n, 1);
        chk("overrun flag", ovr[0], 1);

        // Tick landing on the AGC->IDLE edge still counts as busy.
        do_reset();
        tick[0] = 1'b1;
        @(posedge CLK);
        #1 tick[0] = 1'b0;
        n = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge CLK);
            #1;
            if (otick[0]) n++;
            if (e == 10) tick[0] = 1'b1;
            if (e == 11) tick[0] = 1'b0;
        end
        chk("busy edge ticks", n, 1);
        chk("busy edge overrun", ovr[0], 1);

        // Reset five edges after a tick aborts the sample.
        do_reset();
        mag[0] = 16'h4000; tick[0] = 1'b1;
        @(posedge CLK);
        #1 tick[0] = 1'b0;
        n = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge CLK);
            #1;
            if (otick[0]) n++;
            if (e == 4) RSTb = 1'b0;
            if (e == 6) RSTb = 1'b1;
        end
        chk("midreset ticks", n, 0);
        chk("midreset gain", gout[0], 16);
        chk("midreset overrun", ovr[0], 0);
        chk("midreset audio", aout[0], 0);

        // Random magnitudes and spacings against the model.
        do_reset();
        mdl_reset();
        for (int s = 0; s < 80; s++) begin
            logic [15:0] rm;
            rm = 16'($urandom_range(0, 65535));
            if (s % 4 == 3) rm = 16'($urandom_range(0, 255));
            ea = mdl_step(0, int'(rm));
            sample(0, rm, $urandom_range(12, 16), ea, m_gain[0],
                   $sformatf("rnd%0d", s));
        end
        chk("rnd overrun", ovr[0], 0);

        // Saturation with full-scale starting gain.
        do_reset();
        mdl_reset();
        pulse(1, 16'hFF00, 14, at, n, aud, g);
        chk("sat audio", aud, 32767);
        chk("sat gain", g, 254);
        ea = mdl_step(1, 16'hFF00);
        chk("sat model", aud, ea);

        // DC convergence with a short time constant.
        for (int s = 0; s < 450; s++) begin
            pulse(2, 16'h2000, 20, at, n, aud, g);
            ea = mdl_step(2, 16'h2000);
            chk($sformatf("dc%0d model", s), aud, ea);
            if (s >= 399) chk($sformatf("dc%0d zero", s), aud, 0);
        end
        chk("dc overrun", ovr[2], 0);

        // Release ramp on silence.
        for (int s = 1; s <= 960; s++) begin
            pulse(3, 16'h0000, 16, at, n, aud, g);
            ea = mdl_step(3, 0);
            chk($sformatf("rel%0d gain", s), g, m_gain[3]);
            if (s == 3)   chk("rel gain@3", g, 16);
            if (s == 4)   chk("rel gain@4", g, 17);
            if (s == 955) chk("rel gain@955", g, 254);
            if (s == 956) chk("rel gain@956", g, 255);
            if (s == 960) chk("rel gain@960", g, 255);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
